// File: rtl/caches_types_pkg.sv
// Shared cache types: FSM state, frame layout and default address split.
package caches_types_pkg;

    localparam int unsigned WORD_W      = 32;
    // Frame tag field is wide enough for the smallest legal geometry (SETS=2);
    // narrower tags are stored zero-extended.
    localparam int unsigned FRAME_TAG_W = 30;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic                   valid;
        logic [FRAME_TAG_W-1:0] tag;
        logic [WORD_W-1:0]      data;
    } icache_frame_t;

    // Address split for the default 16-frame geometry.
    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bo;
    } icache_addr_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame.
// Datapath side : imemREN/imemaddr in, ihit/imemload out (zero-latency lookup).
// Memory side   : iREN/iaddr out, iwait/iload in (single-word fill on a miss).
// Perf counters : hit_count (cycles with ihit), miss_count (fills started); both saturate.
module icache
    import caches_types_pkg::*;
#(
    parameter int unsigned SETS  = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [31:0]       imemaddr,
    output logic              ihit,
    output logic [31:0]       imemload,
    output logic              iREN,
    output logic [31:0]       iaddr,
    input  logic              iwait,
    input  logic [31:0]       iload,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_frame_t    frames_q [SETS];
    icache_state_t    state_q,    state_d;
    logic [31:0]      miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0] hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             fill_we;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic             hit;
    logic             unused_bo;

    assign req_idx   = imemaddr[IDX_W+1:2];
    assign req_tag   = imemaddr[31:IDX_W+2];
    assign fill_idx  = miss_addr_q[IDX_W+1:2];
    assign fill_tag  = miss_addr_q[31:IDX_W+2];
    assign unused_bo = ^imemaddr[1:0];

    // Lookup sees the frame contents as of the start of the cycle, so a fill
    // landing on the same index only becomes visible after the edge.
    assign hit = imemREN & frames_q[req_idx].valid
               & (frames_q[req_idx].tag == FRAME_TAG_W'(req_tag));

    assign ihit       = hit;
    assign imemload   = hit ? frames_q[req_idx].data : 32'h0;
    assign iREN       = (state_q == FILL);
    assign iaddr      = (state_q == FILL) ? miss_addr_q : 32'h0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Next-state: miss detection in IDLE, fill completion in FILL, saturating counters.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_we     = 1'b0;

        if (hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    state_d     = FILL;
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            FILL: begin
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and frame array; reset also drops any fill in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            for (int i = 0; i < int'(SETS); i++) begin
                frames_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            if (fill_we) begin
                frames_q[fill_idx].valid <= 1'b1;
                frames_q[fill_idx].tag   <= FRAME_TAG_W'(fill_tag);
                frames_q[fill_idx].data  <= iload;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a vector table for the default geometry plus a
// small-counter instance exercising saturation across repeated conflict misses.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        s_rst;
    logic        s_ren;
    logic [31:0] s_addr;
    logic        s_ihit;
    logic [31:0] s_load;
    logic        s_iren;
    logic [31:0] s_iaddr;
    logic        s_iwait;
    logic [31:0] s_iload;
    logic [1:0]  s_hit;
    logic [1:0]  s_miss;

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    icache #(.SETS(16), .CNT_W(32)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    icache #(.SETS(2), .CNT_W(2)) u_sat (
        .CLK        (CLK),
        .RST        (s_rst),
        .imemREN    (s_ren),
        .imemaddr   (s_addr),
        .ihit       (s_ihit),
        .imemload   (s_load),
        .iREN       (s_iren),
        .iaddr      (s_iaddr),
        .iwait      (s_iwait),
        .iload      (s_iload),
        .hit_count  (s_hit),
        .miss_count (s_miss)
    );

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        e_ihit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_hit;
        logic [31:0] e_miss;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic ren, input logic [31:0] addr,
                                input logic iw, input logic [31:0] ild,
                                input logic eh, input logic [31:0] el, input logic er,
                                input logic [31:0] ea, input logic [31:0] ehc,
                                input logic [31:0] emc);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.iwait = iw; v.iload = ild;
        v.e_ihit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea;
        v.e_hit = ehc; v.e_miss = emc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sat_fetch(input logic [31:0] addr, input logic [31:0] data, input string tag);
        bit seen = 1'b0;
        s_ren   = 1'b1;
        s_addr  = addr;
        s_iload = data;
        s_iwait = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            if (s_ihit) seen = 1'b1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        check($sformatf("%s ihit", tag), 32'(s_ihit), 32'd1);
        check($sformatf("%s imemload", tag), s_load, data);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Default geometry: idx = addr[5:2]; 0x40, 0x80, 0x100 share idx 0.
        vecs[0]  = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       0,32'h0,  0,0);
        vecs[1]  = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       1,32'h40, 0,1);
        vecs[2]  = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       1,32'h40, 0,1);
        vecs[3]  = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       1,32'h40, 0,1);
        vecs[4]  = mk(0,1,32'h40, 0,32'h20010005, 0,32'h0,       1,32'h40, 0,1);
        vecs[5]  = mk(0,1,32'h40, 1,32'h0,        1,32'h20010005,0,32'h0,  0,1);
        vecs[6]  = mk(0,1,32'h40, 1,32'h0,        1,32'h20010005,0,32'h0,  1,1);
        vecs[7]  = mk(0,1,32'h44, 0,32'h11110044, 0,32'h0,       0,32'h0,  2,1);
        vecs[8]  = mk(0,1,32'h44, 0,32'h11110044, 0,32'h0,       1,32'h44, 2,2);
        vecs[9]  = mk(0,1,32'h40, 1,32'h0,        1,32'h20010005,0,32'h0,  2,2);
        vecs[10] = mk(0,0,32'h44, 1,32'h0,        0,32'h0,       0,32'h0,  3,2);
        vecs[11] = mk(0,1,32'h80, 1,32'h0,        0,32'h0,       0,32'h0,  3,2);
        vecs[12] = mk(0,1,32'h80, 0,32'h33330080, 0,32'h0,       1,32'h80, 3,3);
        vecs[13] = mk(0,1,32'h80, 1,32'h0,        1,32'h33330080,0,32'h0,  3,3);
        vecs[14] = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       0,32'h0,  4,3);
        vecs[15] = mk(0,1,32'h40, 0,32'h20010005, 0,32'h0,       1,32'h40, 4,4);
        vecs[16] = mk(0,1,32'h40, 1,32'h0,        1,32'h20010005,0,32'h0,  4,4);
        vecs[17] = mk(0,1,32'h100,1,32'h0,        0,32'h0,       0,32'h0,  5,4);
        vecs[18] = mk(0,1,32'h40, 1,32'h0,        1,32'h20010005,1,32'h100,5,5);
        vecs[19] = mk(0,1,32'h40, 0,32'h44440100, 1,32'h20010005,1,32'h100,6,5);
        vecs[20] = mk(0,1,32'h100,1,32'h0,        1,32'h44440100,0,32'h0,  7,5);
        vecs[21] = mk(0,0,32'h40, 1,32'h0,        0,32'h0,       0,32'h0,  8,5);
        vecs[22] = mk(0,1,32'h40, 1,32'h0,        0,32'h0,       0,32'h0,  8,5);
        vecs[23] = mk(1,1,32'h40, 1,32'h0,        0,32'h0,       1,32'h40, 8,6);
        vecs[24] = mk(0,0,32'h40, 1,32'h0,        0,32'h0,       0,32'h0,  0,0);
        for (int k = 25; k < 30; k++)
            vecs[k] = mk(0,0,32'h100,1,32'h0,     0,32'h0,       0,32'h0,  0,0);
        vecs[30] = mk(0,1,32'h100,0,32'h55550100, 0,32'h0,       0,32'h0,  0,0);
        vecs[31] = mk(0,1,32'h100,0,32'h55550100, 0,32'h0,       1,32'h100,0,1);
        vecs[32] = mk(0,1,32'h100,1,32'h0,        1,32'h55550100,0,32'h0,  0,1);

        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        s_rst = 1'b1; s_ren = 1'b0; s_addr = '0; s_iwait = 1'b1; s_iload = '0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge CLK);
            #1;
            RST      = vecs[i].rst;
            imemREN  = vecs[i].ren;
            imemaddr = vecs[i].addr;
            iwait    = vecs[i].iwait;
            iload    = vecs[i].iload;
            if (i == 0) s_rst = 1'b0;
            @(negedge CLK);
            check($sformatf("v%0d ihit", i),       32'(ihit),  32'(vecs[i].e_ihit));
            check($sformatf("v%0d imemload", i),   imemload,   vecs[i].e_load);
            check($sformatf("v%0d iREN", i),       32'(iREN),  32'(vecs[i].e_iren));
            check($sformatf("v%0d iaddr", i),      iaddr,      vecs[i].e_iaddr);
            check($sformatf("v%0d hit_count", i),  hit_count,  vecs[i].e_hit);
            check($sformatf("v%0d miss_count", i), miss_count, vecs[i].e_miss);
        end

        // Two-frame, 2-bit-counter instance: 0x0 and 0x8 conflict on idx 0.
        @(posedge CLK);
        #1;
        sat_fetch(32'h0, 32'hA000_0000, "sat f0");
        @(negedge CLK);
        check("sat miss after f0", 32'(s_miss), 32'd1);
        check("sat hit after f0",  32'(s_hit),  32'd1);
        @(posedge CLK);
        #1;
        sat_fetch(32'h8, 32'hB000_0008, "sat f1");
        sat_fetch(32'h0, 32'hA000_0000, "sat f2");
        sat_fetch(32'h8, 32'hB000_0008, "sat f3");
        sat_fetch(32'h4, 32'hC000_0004, "sat f4");
        s_ren = 1'b0;
        @(negedge CLK);
        check("sat miss saturated", 32'(s_miss), 32'd3);
        check("sat hit saturated",  32'(s_hit),  32'd3);
        check("sat idle iREN",      32'(s_iren), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
